// File: rtl/jff_pkg.sv
// Shared mode encodings and per-channel next-state function for the flip-flop bank.
`default_nettype none

package jff_pkg;

  localparam logic [1:0] MODE_SR = 2'd0;
  localparam logic [1:0] MODE_JK = 2'd1;
  localparam logic [1:0] MODE_D  = 2'd2;
  localparam logic [1:0] MODE_T  = 2'd3;

  // Returns {illegal, q_next}; SR 11 holds q and raises illegal instead of going unknown.
  function automatic logic [1:0] next_q(input logic [1:0] mode, input logic a,
                                        input logic b, input logic q);
    logic [1:0] r;
    r = {1'b0, q};
    case (mode)
      MODE_SR: begin
        case ({a, b})
          2'b01:   r = 2'b00;
          2'b10:   r = 2'b01;
          2'b11:   r = {1'b1, q};
          default: r = {1'b0, q};
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b01:   r = 2'b00;
          2'b10:   r = 2'b01;
          2'b11:   r = {1'b0, ~q};
          default: r = {1'b0, q};
        endcase
      end
      MODE_D:  r = {1'b0, a};
      default: r = {1'b0, q ^ a};
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jffcell.sv
// One flip-flop channel: state bit, registered illegal flag and mode-selected next-state logic.
`default_nettype none

module jffcell
  import jff_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  output logic       q,
  output logic       illegal,
  output logic       illegal_nxt
);

  logic [1:0] nxt;

  assign nxt         = next_q(mode, a, b, q);
  assign illegal_nxt = en & nxt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RESET_VAL;
      illegal <= 1'b0;
    end else begin
      illegal <= illegal_nxt;
      if (en) q <= nxt[0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/jflipflop_bank.sv
// WIDTH-channel SR/JK/D/T flip-flop bank with illegal-input flags.
// Define JFF_ILLEGAL_CNT_EN to build the saturating illegal-event counter.
`default_nettype none

module jflipflop_bank
  import jff_pkg::*;
#(
  parameter int                 WIDTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
  parameter int                 CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [2*WIDTH-1:0]   ctl,
  input  logic                 clr_cnt,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qbar,
  output logic [WIDTH-1:0]     illegal,
  output logic [CNT_W-1:0]     illegal_cnt
);

  logic [WIDTH-1:0] illegal_nxt;

  assign qbar = ~q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jffcell #(
      .RESET_VAL (RESET_VAL[i])
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode        (mode),
      .a           (ctl[2*i+1]),
      .b           (ctl[2*i]),
      .q           (q[i]),
      .illegal     (illegal[i]),
      .illegal_nxt (illegal_nxt[i])
    );
  end

`ifdef JFF_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt <= '0;
    end else if ((|illegal_nxt) && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign illegal_cnt = cnt;
`else
  logic unused_cnt_inputs;

  assign unused_cnt_inputs = clr_cnt;
  assign illegal_cnt       = '0;
`endif

endmodule

`default_nettype wire
